game_state_controller: RTL and testbench

Top-level game flow FSM, downstream of the enemy controller and upstream of the stage timer and graphic output. Consumes the per-enemy alive vector and the player and enemy positions, and detects enemy kills and player–enemy contact. Maintains lives and a BCD score, and drives stage_rst to hold or release the game timer. Supplies state, lives, score and player_visible to the HUD and sprite-mux logic.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_state_controller_bcd_score_counter.sv | 47 ++++
 rtl/game_state_controller.sv | 146 ++++++++++++++
 tb/tb_game_state_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
// States, sprite geometry, screen size and BCD digit type.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  localparam int SPRITE_SIZE = 32;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/game_state_controller_bcd_score_counter.sv
// Saturating four-digit BCD score counter (holds at 9999).
// Ports: clk25, rst_n, clr (sync clear, wins), inc, score_bcd.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] score_bcd
);

  logic [15:0] nxt;
  logic        carry;
  logic        sat;
  bcd_digit_t  d;

  assign sat = (score_bcd == 16'h9999);

  always_comb begin
    nxt   = score_bcd;
    carry = 1'b1;
    d     = '0;
    for (int i = 0; i < 4; i++) begin
      d = score_bcd[i*4 +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = d + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd <= '0;
    end else if (clr) begin
      score_bcd <= '0;
    end else if (inc && !sat) begin
      score_bcd <= nxt;
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Game flow FSM: start, contact/lives, kill scoring, stage clear.
// In: clk25 rst_n frame_tick btn_fire positions alive seconds; out: state stage_rst lives score_bcd player_visible.
module game_state_controller #(
  parameter int ENEMY_COUNT   = 23,
  parameter int SPRITE_SIZE   = game_pkg::SPRITE_SIZE,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int CLEAR_SECONDS = 60
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      btn_fire,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [10*ENEMY_COUNT-1:0] enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0] enemy_y_flat,
  input  logic [ENEMY_COUNT-1:0]    enemy_alive_flat,
  input  logic [7:0]                seconds,
  output logic [1:0]                state,
  output logic                      stage_rst,
  output logic [1:0]                lives,
  output logic [15:0]               score_bcd,
  output logic                      player_visible
);
  import game_pkg::*;

  localparam int KW = $clog2(ENEMY_COUNT + 1);

  state_t                 st;
  logic                   s1, s2, s3;
  logic                   fire_edge, start;
  logic [ENEMY_COUNT-1:0] alive_prev;
  logic                   play_prev;
  logic [KW-1:0]          kills;
  logic [5:0]             pending;
  logic [7:0]             psum;
  logic                   drain;
  logic [6:0]             invuln;
  logic [2:0]             fcnt;
  logic                   hit_any, death, clear_ok;

  assign state     = st;
  assign fire_edge = s2 & ~s3;
  assign start     = fire_edge & (st != ST_PLAY);
  assign drain     = |pending;

  always_comb begin
    kills = '0;
    if (st == ST_PLAY && play_prev)
      kills = KW'($countones(alive_prev & ~enemy_alive_flat));
  end

  // drain only when pending >= 1, so no underflow
  assign psum = 8'(pending) + 8'(kills) - 8'(drain);

  always_comb begin
    logic signed [10:0] dx, dy;
    logic [10:0]        ax, ay;
    hit_any = 1'b0;
    dx = '0; dy = '0; ax = '0; ay = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      dx = $signed({1'b0, player_x}) - $signed({1'b0, enemy_x_flat[i*10 +: 10]});
      dy = $signed({1'b0, player_y}) - $signed({1'b0, enemy_y_flat[i*10 +: 10]});
      ax = dx[10] ? 11'(-dx) : 11'(dx);
      ay = dy[10] ? 11'(-dy) : 11'(dy);
      if (enemy_alive_flat[i] && ax < 11'(SPRITE_SIZE) && ay < 11'(SPRITE_SIZE))
        hit_any = 1'b1;
    end
  end

  assign death = (st == ST_PLAY) & frame_tick & (invuln == '0)
               & hit_any & (lives <= 2'd1);
  assign clear_ok = (seconds >= 8'(CLEAR_SECONDS))
                  & (enemy_alive_flat == '0);

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      alive_prev <= '0;
      play_prev  <= 1'b0;
      pending    <= '0;
      fcnt       <= '0;
    end else begin
      s1         <= btn_fire;
      s2         <= s1;
      s3         <= s2;
      alive_prev <= enemy_alive_flat;
      play_prev  <= (st == ST_PLAY);
      if (frame_tick) fcnt <= fcnt + 3'd1;
      if (start)              pending <= '0;
      else if (psum > 8'd63)  pending <= 6'd63;
      else                    pending <= psum[5:0];
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      st             <= ST_IDLE;
      stage_rst      <= 1'b1;
      lives          <= 2'(START_LIVES);
      invuln         <= '0;
      player_visible <= 1'b1;
    end else begin
      player_visible <= (invuln == '0) | fcnt[2];
      unique case (st)
        ST_PLAY: begin
          if (frame_tick) begin
            if (invuln != '0) begin
              invuln <= invuln - 7'd1;
            end else if (hit_any) begin
              invuln <= 7'(INVULN_FRAMES);
              if (lives != '0) lives <= lives - 2'd1;
            end
          end
          if (death) begin
            st        <= ST_OVER;
            stage_rst <= 1'b1;
          end else if (clear_ok) begin
            st        <= ST_CLEAR;
            stage_rst <= 1'b1;
          end
        end
        ST_IDLE, ST_OVER, ST_CLEAR: begin
          if (fire_edge) begin
            st        <= ST_PLAY;
            stage_rst <= 1'b0;
            lives     <= 2'(START_LIVES);
            invuln    <= '0;
          end
        end
      endcase
    end
  end

  bcd_score_counter u_score (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (drain),
    .score_bcd (score_bcd)
  );

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus random run.
// Checks outputs against an integer-level behavioural model.
module tb_game_state_controller;
  localparam int N = 23;

  logic            clk25 = 1'b0;
  logic            rst_n = 1'b1;
  logic            frame_tick = 1'b0;
  logic            btn_fire = 1'b0;
  logic [9:0]      player_x = 10'd100;
  logic [9:0]      player_y = 10'd100;
  logic [10*N-1:0] ex_f = '0;
  logic [10*N-1:0] ey_f = '0;
  logic [N-1:0]    alive = '1;
  logic [7:0]      seconds = 8'd0;
  logic [1:0]      state;
  logic            stage_rst;
  logic [1:0]      lives;
  logic [15:0]     score_bcd;
  logic            pv;

  int checks = 0;
  int errors = 0;

  game_state_controller dut (
    .clk25            (clk25),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .btn_fire         (btn_fire),
    .player_x         (player_x),
    .player_y         (player_y),
    .enemy_x_flat     (ex_f),
    .enemy_y_flat     (ey_f),
    .enemy_alive_flat (alive),
    .seconds          (seconds),
    .state            (state),
    .stage_rst        (stage_rst),
    .lives            (lives),
    .score_bcd        (score_bcd),
    .player_visible   (pv)
  );

  always #20 clk25 = ~clk25;

  // behavioural model: states 0 idle, 1 play, 2 over, 3 clear
  int m_st = 0, m_lives = 3, m_score = 0, m_pend = 0;
  int m_inv = 0, m_fcnt = 0;
  bit m_pv = 1, s1 = 0, s2 = 0, s3 = 0, m_pplay = 0;
  logic [N-1:0] m_aprev = '0;

  function automatic bit near(int a, int b);
    return (a - b < 32) && (b - a < 32);
  endfunction

  function automatic bit m_hit();
    for (int i = 0; i < N; i++)
      if (alive[i] && near(int'(player_x), int'(ex_f[i*10 +: 10]))
          && near(int'(player_y), int'(ey_f[i*10 +: 10])))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_st = 0; m_lives = 3; m_score = 0; m_pend = 0;
    m_inv = 0; m_fcnt = 0; m_pv = 1;
    s1 = 0; s2 = 0; s3 = 0; m_pplay = 0; m_aprev = '0;
  endtask

  task automatic m_step();
    bit fe, inc, hit;
    int kills, np;
    fe = s2 && !s3;
    s3 = s2; s2 = s1; s1 = btn_fire;
    kills = (m_st == 1 && m_pplay) ? $countones(m_aprev & ~alive) : 0;
    m_pplay = (m_st == 1);
    m_aprev = alive;
    inc = (m_pend > 0);
    np = m_pend + kills - (inc ? 1 : 0);
    m_pend = (np > 63) ? 63 : np;
    if (inc && m_score < 9999) m_score++;
    m_pv = (m_inv == 0) || (((m_fcnt >> 2) & 1) != 0);
    hit = m_hit();
    if (frame_tick) m_fcnt++;
    if (m_st == 1) begin
      if (frame_tick) begin
        if (m_inv > 0) m_inv--;
        else if (hit) begin
          m_inv = 120;
          if (m_lives == 1) begin m_lives = 0; m_st = 2; end
          else m_lives--;
        end
      end
      if (m_st == 1 && seconds >= 60 && alive == '0) m_st = 3;
    end else if (fe) begin
      m_st = 1; m_lives = 3; m_score = 0; m_pend = 0; m_inv = 0;
    end
  endtask

  always @(posedge clk25 or negedge rst_n)
    if (!rst_n) m_reset();
    else m_step();

  function automatic logic [15:0] bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {2'(m_st), (m_st != 1), 2'(m_lives), bcd(m_score), m_pv};
  endfunction

  wire [21:0] dut_vec = {state, stage_rst, lives, score_bcd, pv};
  localparam logic [21:0] RST_VEC = {2'b00, 1'b1, 2'd3, 16'h0000, 1'b1};

  task automatic cyc(int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(3);
  endtask

  task automatic set_enemy(int i, int x, int y);
    ex_f[i*10 +: 10] = 10'(x);
    ey_f[i*10 +: 10] = 10'(y);
  endtask

  task automatic far_all();
    for (int i = 0; i < N; i++) set_enemy(i, 600, 440);
    player_x = 10'd100;
    player_y = 10'd100;
  endtask

  task automatic restart();
    far_all();
    alive = '1;
    seconds = 8'd0;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    btn_fire = 1'b1;
    cyc(3);
    btn_fire = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    cyc(1);
    #5 rst_n = 1'b0;
    cyc(2);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_const got %h want %h", dut_vec, RST_VEC);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got %h want %h", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_start();
    far_all();
    alive = '1;
    btn_fire = 1'b1;
    cyc(2);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL start_early got %b want 00", state);
    end
    cyc(1);
    checks++;
    if (dut_vec !== {2'b01, 1'b0, 2'd3, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL start_play got %h want play/3/0000", dut_vec);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL start_model got %h want %h", dut_vec, exp_vec());
    end
    btn_fire = 1'b0;
    cyc(2);
  endtask

  task automatic test_kills();
    alive[0] = 1'b0; alive[5] = 1'b0; alive[20] = 1'b0;
    cyc(4);
    checks++;
    if (score_bcd !== 16'h0003 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL kills3 got %h want 0003 (model %h)", score_bcd, exp_vec());
    end
    for (int r = 0; r < 4; r++) begin
      alive = '1;
      cyc(1);
      alive = '0;
      cyc(30);
    end
    alive = '1;
    cyc(1);
    alive = ~N'(4'hF);
    cyc(10);
    checks++;
    if (score_bcd !== 16'h0099 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL kills99 got %h want 0099", score_bcd);
    end
    alive[4] = 1'b0;
    cyc(3);
    checks++;
    if (score_bcd !== 16'h0100 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL carry100 got %h want 0100", score_bcd);
    end
  endtask

  task automatic test_contact();
    int toggles;
    logic last;
    alive = '1;
    far_all();
    set_enemy(0, 131, 131);
    cyc(1);
    frame();
    checks++;
    if (lives !== 2'd2 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL hit1 got %h want lives 2 (model %h)", dut_vec, exp_vec());
    end
    toggles = 0;
    last = pv;
    for (int f = 0; f < 120; f++) begin
      frame();
      if (pv !== last) toggles++;
      last = pv;
      checks++;
      if (lives !== 2'd2 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL invuln f%0d got %h want %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (toggles < 28) begin
      errors++;
      $display("FAIL blink got %0d toggles want >=28", toggles);
    end
    frame();
    checks++;
    if (lives !== 2'd1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL hit121 got %h want lives 1", dut_vec);
    end
  endtask

  task automatic test_edges();
    restart();
    set_enemy(0, 132, 100);
    frame();
    checks++;
    if (lives !== 2'd3 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL edge32 got lives %0d want 3", lives);
    end
    player_x = 10'd31;
    player_y = 10'd31;
    set_enemy(0, 0, 0);
    frame();
    checks++;
    if (lives !== 2'd2 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL edge31 got lives %0d want 2", lives);
    end
  endtask

  task automatic test_death();
    restart();
    seconds = 8'd60;
    set_enemy(0, 100, 100);
    frame();
    repeat (2) begin
      repeat (120) frame();
      frame();
    end
    checks++;
    if (dut_vec !== {2'b10, 1'b1, 2'd0, 16'h0000, m_pv} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL death got %h want over/0 (model %h)", dut_vec, exp_vec());
    end
    btn_fire = 1'b1;
    cyc(3);
    btn_fire = 1'b0;
    far_all();
    cyc(1);
    checks++;
    if (dut_vec !== {2'b01, 1'b0, 2'd3, 16'h0000, 1'b1} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL restart got %h want play/3/0000", dut_vec);
    end
  endtask

  task automatic test_clear();
    seconds = 8'd59;
    alive = '0;
    cyc(40);
    checks++;
    if (state !== 2'b01 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear59 got %h want play", dut_vec);
    end
    seconds = 8'd60;
    cyc(1);
    checks++;
    if (state !== 2'b11 || stage_rst !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear60 got %h want clear", dut_vec);
    end
    cyc(10);
    checks++;
    if (score_bcd !== 16'h0023 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear_hold got %h want 0023", score_bcd);
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RST_VEC || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_rst got %h want %h", dut_vec, RST_VEC);
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 3000; c++) begin
      frame_tick = ($urandom % 4 == 0);
      if ($urandom % 16 == 0) begin
        player_x = 10'($urandom_range(50, 150));
        player_y = 10'($urandom_range(50, 150));
      end
      if ($urandom % 8 == 0)
        set_enemy($urandom % N, $urandom_range(40, 220), $urandom_range(40, 220));
      if ($urandom % 60 == 0) alive = '1;
      else if ($urandom % 6 == 0) alive[$urandom % N] = 1'b0;
      seconds = 8'($urandom_range(55, 65));
      if ($urandom % 40 == 0) btn_fire = ~btn_fire;
      cyc(1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_kills();
    test_contact();
    test_edges();
    test_death();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
